// File: rtl/dv_seq_ctrl.sv
// dv_seq_ctrl: DV test sequencer (power-up, DUT reset hold, per-channel start, drain, watchdog).
// Latency: every output is a flop, updated on the clk edge that takes the phase decision.
// Backpressure: none; channels hold stim_done/test_done, optional watchdog via DV_SEQ_WATCHDOG_EN.
module dv_seq_ctrl #(
    parameter int N              = 2,
    parameter int CW             = 16,
    parameter int PWR_CYCLES     = 4,
    parameter int RST_CYCLES     = 8,
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] ch_mask,
    input  logic [N-1:0] dut_active,
    input  logic [N-1:0] stim_done,
    input  logic [N-1:0] test_done,
    output logic         vdd_en,
    output logic         dut_nreset,
    output logic [N-1:0] start,
    output logic         done,
    output logic         fail,
    output logic [2:0]   state
);

    if (N < 1 || N > 32 || PWR_CYCLES < 1 || RST_CYCLES < 1 || DRAIN_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CW) - 1) begin : g_bad_cfg
        $error("dv_seq_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_RAMP  = 3'd1,
        S_RSTH  = 3'd2,
        S_WAIT  = 3'd3,
        S_RUN   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6,
        S_FAIL  = 3'd7
    } state_e;

    localparam logic [CW-1:0] PWR_LAST   = CW'(PWR_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  mreg_q, mreg_d;
    logic [N-1:0]  start_q, start_d;
    logic          vdd_en_q, vdd_en_d;
    logic          dut_nreset_q, dut_nreset_d;
    logic          done_q, done_d;
    logic [N-1:0]  chdone;
    logic          all_started;
    logic          all_done;

    // Exit from WAIT looks at starts already registered, so it lands one cycle after the last start.
    assign all_started = (start_q & mreg_q) == mreg_q;
    assign chdone      = mreg_q & stim_done & test_done;
    assign all_done    = chdone == mreg_q;

`ifdef DV_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wdog_q, wdog_d;
    logic          fail_q, fail_d;
    logic          wd_expired;

    assign wd_expired = wdog_q == WD_LAST;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = sat_inc(cnt_q);
        mreg_d  = mreg_q;
        start_d = start_q;
`ifdef DV_SEQ_WATCHDOG_EN
        wdog_d  = wdog_q;
`endif
        case (state_q)
            S_OFF: begin
                state_d = S_RAMP;
                cnt_d   = '0;
            end
            S_RAMP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_RSTH;
                    cnt_d   = '0;
                end
            end
            S_RSTH: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    mreg_d  = ch_mask;
`ifdef DV_SEQ_WATCHDOG_EN
                    wdog_d  = '0;
`endif
                end
            end
            S_WAIT: begin
                start_d = start_q | (mreg_q & dut_active);
`ifdef DV_SEQ_WATCHDOG_EN
                wdog_d  = sat_inc(wdog_q);
`endif
                if (all_started) begin
                    state_d = S_RUN;
`ifdef DV_SEQ_WATCHDOG_EN
                end else if (wd_expired) begin
                    state_d = S_FAIL;
`endif
                end
            end
            S_RUN: begin
`ifdef DV_SEQ_WATCHDOG_EN
                wdog_d = sat_inc(wdog_q);
`endif
                if (all_done) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
`ifdef DV_SEQ_WATCHDOG_EN
                end else if (wd_expired) begin
                    state_d = S_FAIL;
`endif
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            default: begin
            end
        endcase

        // Outputs are a function of the phase being entered, so they line up with state.
        vdd_en_d     = state_d != S_OFF;
        dut_nreset_d = state_d inside {S_WAIT, S_RUN, S_DRAIN, S_DONE};
        done_d       = state_d == S_DONE;
        if (state_d inside {S_DONE, S_FAIL}) begin
            start_d = '0;
        end
`ifdef DV_SEQ_WATCHDOG_EN
        fail_d = state_d == S_FAIL;
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            mreg_q       <= '0;
            start_q      <= '0;
            vdd_en_q     <= 1'b0;
            dut_nreset_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mreg_q       <= mreg_d;
            start_q      <= start_d;
            vdd_en_q     <= vdd_en_d;
            dut_nreset_q <= dut_nreset_d;
            done_q       <= done_d;
        end
    end

`ifdef DV_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wdog_q <= '0;
            fail_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            fail_q <= fail_d;
        end
    end

    assign fail = fail_q;
`else
    assign fail = 1'b0;
`endif

    assign vdd_en     = vdd_en_q;
    assign dut_nreset = dut_nreset_q;
    assign start      = start_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule
